// File: rtl/float_to_fixed_stage.sv
// IEEE-754 single to signed fixed point with iterative,
// one-bit-per-cycle alignment on a start/done handshake.
module float_to_fixed_stage #(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      dataa,
  output logic [OUT_W-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             sat
);
  typedef enum logic [1:0] {
    IDLE, CLASSIFY, SHIFT, FINISH
  } state_t;

  localparam logic signed [10:0] D_OFF =
    11'(FRAC_BITS - 150);
  localparam logic [10:0] SAT_E =
    11'(127 + OUT_W - 1 - FRAC_BITS);
  localparam logic [OUT_W-1:0] POS_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX =
    {1'b1, {(OUT_W-1){1'b0}}};

  state_t state, nxt;
  logic s, left, satf;
  logic [7:0] e;
  logic [7:0] cnt;
  logic [OUT_W-1:0] mag;
  logic signed [10:0] d;
  logic [7:0] n_abs;
  logic is_inf, is_big, is_zero, special;

  // d is the left-shift distance that places the binary point
  assign d = $signed({3'b000, e}) + D_OFF;
  assign n_abs = d[10] ? 8'(-d) : 8'(d);
  assign is_inf = (e == 8'hFF);
  assign is_big = ({3'b000, e} >= SAT_E);
  assign is_zero = (e == 8'h00) || (d < -11'sd24);
  assign special = is_inf | is_big | is_zero;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = CLASSIFY;
      CLASSIFY:
        if (special || d == 11'sd0) nxt = FINISH;
        else nxt = SHIFT;
      SHIFT: if (cnt == 8'd1) nxt = FINISH;
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      sat    <= 1'b0;
      s      <= 1'b0;
      left   <= 1'b0;
      satf   <= 1'b0;
      e      <= '0;
      cnt    <= '0;
      mag    <= '0;
    end else if (clk_en) begin
      state <= nxt;
      done  <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            s    <= dataa[31];
            e    <= dataa[30:23];
            mag  <= {{(OUT_W-24){1'b0}},
                     |dataa[30:23], dataa[22:0]};
            satf <= 1'b0;
            busy <= 1'b1;
          end
        CLASSIFY:
          if (is_inf) begin
            satf <= 1'b1;
            // NaN saturates positive regardless of sign
            if (|mag[22:0]) s <= 1'b0;
          end else if (is_big) begin
            satf <= 1'b1;
          end else if (is_zero) begin
            mag <= '0;
          end else begin
            cnt  <= n_abs;
            left <= !d[10];
          end
        SHIFT: begin
          mag <= left ? (mag << 1) : (mag >> 1);
          cnt <= cnt - 8'd1;
        end
        FINISH: begin
          if (satf) result <= s ? NEG_MAX : POS_MAX;
          else result <= s ? -mag : mag;
          sat  <= satf;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_to_fixed_stage.sv
// Scoreboard bench for float_to_fixed_stage: expected
// result, sat and completion cycle queued per start.
module tb_float_to_fixed_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        sat;

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  float_to_fixed_stage dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .start(start), .dataa(dataa), .result(result),
    .done(done), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done result=%h", result);
      end else begin
        x = q.pop_front();
        total++;
        if (result !== x.res) begin
          bad++;
          $display("FAIL result got=%h exp=%h",
                   result, x.res);
        end
        total++;
        if (sat !== x.sat) begin
          bad++;
          $display("FAIL sat got=%b exp=%b", sat, x.sat);
        end
        total++;
        if (cyc !== x.cyc) begin
          bad++;
          $display("FAIL latency cycle got=%0d exp=%0d",
                   cyc, x.cyc);
        end
      end
    end
  endtask

  task automatic convert(input logic [31:0] a,
                         input logic [31:0] r,
                         input logic sv, input int lat,
                         input int extra);
    dataa = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    q.push_back('{r, sv, cyc + lat - 1 + extra});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++)
      tick();
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout pending=%0d exp=0", q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_bit(input string nm,
                           input logic got,
                           input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h exp=0", result);
    end
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_sat", sat, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    convert(32'h437F0000, 32'h3FC00000, 1'b0, 9, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check_bit("busy_during", busy, 1'b1);
    end
    wait_idle();
    check_bit("busy_after", busy, 1'b0);
    convert(32'h3F800000, 32'h00400000, 1'b0, 4, 0);
    wait_idle();
    convert(32'hBF000000, 32'hFFE00000, 1'b0, 5, 0);
    wait_idle();
    convert(32'hC37F0000, 32'hC0400000, 1'b0, 9, 0);
    wait_idle();
  endtask

  task automatic test_bounds();
    convert(32'h43FFFFFF, 32'h7FFFFF80, 1'b0, 10, 0);
    wait_idle();
    convert(32'h34800000, 32'h00000001, 1'b0, 26, 0);
    wait_idle();
    convert(32'h34000000, 32'h00000000, 1'b0, 27, 0);
    wait_idle();
  endtask

  task automatic test_sat();
    convert(32'h44800000, 32'h7FFFFFFF, 1'b1, 3, 0);
    wait_idle();
    convert(32'hC4800000, 32'h80000000, 1'b1, 3, 0);
    wait_idle();
    convert(32'h44000000, 32'h7FFFFFFF, 1'b1, 3, 0);
    wait_idle();
    convert(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 3, 0);
    wait_idle();
    convert(32'hFFC00000, 32'h7FFFFFFF, 1'b1, 3, 0);
    wait_idle();
    convert(32'hFF800000, 32'h80000000, 1'b1, 3, 0);
    wait_idle();
  endtask

  task automatic test_zero();
    convert(32'h00000000, 32'h0, 1'b0, 3, 0);
    wait_idle();
    convert(32'h80000000, 32'h0, 1'b0, 3, 0);
    wait_idle();
    convert(32'h00400000, 32'h0, 1'b0, 3, 0);
    wait_idle();
    convert(32'h2EDBE6FF, 32'h0, 1'b0, 3, 0);
    wait_idle();
  endtask

  task automatic test_clk_en();
    convert(32'h437F0000, 32'h3FC00000, 1'b0, 9, 5);
    tick();
    tick();
    clk_en = 1'b0;
    repeat (5) tick();
    check_bit("busy_stalled", busy, 1'b1);
    clk_en = 1'b1;
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    convert(32'h3F800000, 32'h00400000, 1'b0, 4, 0);
    dataa = 32'h44800000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    convert(32'h3F800000, 32'h00400000, 1'b0, 4, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++)
      tick();
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL b2b_first_done missing exp=done");
      q.delete();
    end
    convert(32'hBF000000, 32'hFFE00000, 1'b0, 5, 0);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    convert(32'h437F0000, 32'h3FC00000, 1'b0, 9, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    q.delete();
    total++;
    if (result !== 32'h0) begin
      bad++;
      $display("FAIL midreset_result got=%h exp=0", result);
    end
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_done", done, 1'b0);
    repeat (15) tick();
    convert(32'h3F800000, 32'h00400000, 1'b0, 4, 0);
    wait_idle();
  endtask

  initial begin
    reset = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    dataa = 32'h0;
    test_reset();
    test_normal();
    test_bounds();
    test_sat();
    test_zero();
    test_clk_en();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
